card_dealer: RTL and testbench
==============================

CARD_DEALER -- requirements
Module: card_dealer

Interface
REQ-001 The module SHALL have parameter DECK_SIZE, default 52: number of distinct cards dealt per deck, legal range 2..64.
REQ-002 The module SHALL have parameter DEFAULT_SEED, default 16'hACE1: LFSR seed used after reset and whenever a zero seed is supplied.
REQ-003 The module SHALL have port CLOCK_50  input  1: the single clock; all state changes occur on its rising edge.
REQ-004 The module SHALL have port resetn  input  1: reset, asynchronous and active-low.
REQ-005 The module SHALL have port shuffle_start  input  1: one-cycle pulse that requests a new shuffle using seed.
REQ-006 The module SHALL have port seed  input  16: LFSR seed, sampled only in the cycle shuffle_start=1.
REQ-007 The module SHALL have port draw_req  input  1: one-cycle pulse that requests the next card.
REQ-008 The module SHALL have port card  output  6: value of the dealt card, 0..DECK_SIZE-1.
REQ-009 The module SHALL have port card_valid  output  1: one-cycle strobe marking card as valid.
REQ-010 The module SHALL have port cards_left  output  7: number of undealt cards in the current deck.
REQ-011 The module SHALL have port busy  output  1: high while in the INIT or SHUF state.
REQ-012 The module SHALL have port deck_empty  output  1: high when cards_left=0 and busy=0.

Function
REQ-013 The module SHALL hold the deck in an internal DECK_SIZE x 6-bit register array.
REQ-014 The module SHALL have the states INIT, SHUF, READY and DEAL.
REQ-015 In INIT, the module SHALL write deck[i]=i for i=0..DECK_SIZE-1, one entry per cycle, then enter SHUF with i=DECK_SIZE-1.
REQ-016 SHUF SHALL perform a Fisher-Yates shuffle: j=lfsr[5:0]; if j>i, advance the LFSR and retry; otherwise swap deck[i] and deck[j], decrement i and advance the LFSR.
REQ-017 When SHUF completes the swap for i=1, the module SHALL set the read pointer to 0, set cards_left=DECK_SIZE and enter READY.
REQ-018 The LFSR SHALL be a 16-bit Galois LFSR with mask 16'hB400 that advances at most once per cycle.
REQ-019 A zero seed SHALL be replaced by DEFAULT_SEED.
REQ-020 In READY, draw_req=1 with cards_left>0 SHALL, one cycle later, produce card=deck[ptr] with card_valid=1 for exactly one cycle, then increment ptr and decrement cards_left.
REQ-021 card SHALL hold its last value until the next deal.
REQ-022 A draw_req received while busy=1, or in the DEAL cycle, SHALL be dropped; requests are not queued and card_valid stays 0.
REQ-023 shuffle_start in any state SHALL abort the current activity and load the LFSR from seed.
REQ-024 After shuffle_start, cards_left SHALL be cleared to 0 and the module SHALL enter INIT.
REQ-025 When shuffle_start and draw_req are high in the same cycle, shuffle_start SHALL win and no card is dealt.
REQ-026 Within one deck, no card value SHALL be dealt twice; each deck SHALL deal every value 0..DECK_SIZE-1 exactly once.
REQ-027 The shuffle sequence SHALL be deterministic: the same seed yields the same deal order.

Reset
REQ-028 While resetn=0, the module SHALL hold card=0, card_valid=0, cards_left=0 and deck_empty=0.
REQ-029 While resetn=0, the module SHALL hold busy=1, ptr=0, lfsr=DEFAULT_SEED and state=INIT.
REQ-030 After resetn deasserts, the module SHALL run INIT and then SHUF automatically with DEFAULT_SEED; no shuffle_start is needed.
REQ-031 A reset asserted mid-shuffle or mid-deal SHALL discard all deck state; the deal order after release SHALL equal the order after power-up.

Configuration
REQ-032 Macro DEALER_AUTO_RESHUFFLE_EN SHALL control what a draw_req does when the deck is empty.
REQ-033 With DEALER_AUTO_RESHUFFLE_EN defined, a draw_req while deck_empty=1 SHALL start INIT, continuing from the current LFSR state (no reseed).
REQ-034 With DEALER_AUTO_RESHUFFLE_EN defined, once READY is reached the pending draw SHALL be served without a further request, with card_valid one cycle after READY.
REQ-035 Without DEALER_AUTO_RESHUFFLE_EN, a draw_req while deck_empty=1 SHALL be ignored, and deck_empty SHALL stay 1 until shuffle_start or reset.

Verification
REQ-036 Reset release with no other stimulus -> busy=1 for at least 2*DECK_SIZE cycles, then busy=0 and cards_left=52.
REQ-037 shuffle_start with seed=16'h1234, then 52 spaced draw_req -> 52 card_valid strobes with all values 0..51 exactly once, cards_left 51..0, then deck_empty=1.
REQ-038 Same seed=16'h1234 applied twice -> identical 52-card sequences; seed=16'h0000 -> sequence equal to the DEFAULT_SEED power-up sequence.
REQ-039 draw_req and shuffle_start in the same cycle -> no card_valid, busy=1 next cycle, cards_left=0; draw_req pulses during busy -> no card_valid.
REQ-040 53rd draw_req -> with DEALER_AUTO_RESHUFFLE_EN: busy rises, then one card_valid after READY, cards_left=51; without it: no card_valid, deck_empty remains 1.
REQ-041 resetn pulsed low after 10 cards dealt -> outputs at reset values; after re-shuffle, first card equals the first card after power-up.

Source files
------------

// File: rtl/card_dealer.sv
// card_dealer: shuffles a DECK_SIZE-card deck with an LFSR-driven
// Fisher-Yates pass, then deals one card per draw request.
// Optional build macro: DEALER_AUTO_RESHUFFLE_EN -- when defined, a draw
// on an empty deck reshuffles (LFSR continues, no reseed) and then serves
// that draw automatically.
module card_dealer #(
    parameter int unsigned DECK_SIZE    = 52,
    parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        shuffle_start,
    input  logic [15:0] seed,
    input  logic        draw_req,
    output logic [5:0]  card,
    output logic        card_valid,
    output logic [6:0]  cards_left,
    output logic        busy,
    output logic        deck_empty
);

    localparam int unsigned IDX_W  = 6;
    localparam int unsigned CNT_W  = 7;
    localparam int unsigned LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DECK_SIZE - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DECK_SIZE);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_SHUF  = 2'd1,
        ST_READY = 2'd2,
        ST_DEAL  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [CNT_W-1:0]    left_q, left_d;
    logic [IDX_W-1:0]    card_q, card_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                empty_q, empty_d;
`ifdef DEALER_AUTO_RESHUFFLE_EN
    logic                pending_q, pending_d;
`endif

    logic [IDX_W-1:0]    deck_q [DECK_SIZE];
    logic [IDX_W-1:0]    swap_j;
    logic [LFSR_W-1:0]   lfsr_adv;
    logic                want_card;
    logic                init_wr;
    logic                swap_en;

    assign swap_j   = lfsr_q[IDX_W-1:0];
    assign lfsr_adv = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_MASK : '0);

`ifdef DEALER_AUTO_RESHUFFLE_EN
    assign want_card = draw_req || pending_q;
`else
    assign want_card = draw_req;
`endif

    // State register and registered outputs
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_INIT;
            idx_q     <= '0;
            ptr_q     <= '0;
            lfsr_q    <= DEFAULT_SEED;
            left_q    <= '0;
            card_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b1;
            empty_q   <= 1'b0;
`ifdef DEALER_AUTO_RESHUFFLE_EN
            pending_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            lfsr_q    <= lfsr_d;
            left_q    <= left_d;
            card_q    <= card_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            empty_q   <= empty_d;
`ifdef DEALER_AUTO_RESHUFFLE_EN
            pending_q <= pending_d;
`endif
        end
    end

    // Next-state logic: shuffle_start overrides everything, else per-state work
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        lfsr_d    = lfsr_q;
        left_d    = left_q;
        card_d    = card_q;
        valid_d   = 1'b0;
        init_wr   = 1'b0;
        swap_en   = 1'b0;
`ifdef DEALER_AUTO_RESHUFFLE_EN
        pending_d = pending_q;
`endif
        if (shuffle_start) begin
            lfsr_d    = (seed == '0) ? DEFAULT_SEED : seed;
            left_d    = '0;
            idx_d     = '0;
            ptr_d     = '0;
            state_d   = ST_INIT;
`ifdef DEALER_AUTO_RESHUFFLE_EN
            pending_d = 1'b0;
`endif
        end else begin
            unique case (state_q)
                ST_INIT: begin
                    init_wr = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_SHUF;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                ST_SHUF: begin
                    lfsr_d = lfsr_adv;
                    if (swap_j <= idx_q) begin
                        swap_en = 1'b1;
                        if (idx_q == IDX_W'(1)) begin
                            state_d = ST_READY;
                            ptr_d   = '0;
                            left_d  = FULL_CNT;
                        end else begin
                            idx_d = idx_q - IDX_W'(1);
                        end
                    end
                end
                ST_READY: begin
                    if (want_card && (left_q != '0)) begin
                        card_d    = deck_q[ptr_q];
                        valid_d   = 1'b1;
                        ptr_d     = ptr_q + IDX_W'(1);
                        left_d    = left_q - CNT_W'(1);
                        state_d   = ST_DEAL;
`ifdef DEALER_AUTO_RESHUFFLE_EN
                        pending_d = 1'b0;
                    end else if (draw_req) begin
                        // empty deck: reshuffle from the current LFSR state
                        idx_d     = '0;
                        state_d   = ST_INIT;
                        pending_d = 1'b1;
`endif
                    end
                end
                ST_DEAL: begin
                    state_d = ST_READY;
                end
                default: begin
                    state_d = ST_INIT;
                end
            endcase
        end
        busy_d  = (state_d == ST_INIT) || (state_d == ST_SHUF);
        empty_d = (left_d == '0) && !busy_d;
    end

    // Deck storage: identity fill during INIT, pairwise swap during SHUF
    always_ff @(posedge CLOCK_50) begin
        if (init_wr) begin
            deck_q[idx_q] <= idx_q;
        end else if (swap_en) begin
            deck_q[idx_q]  <= deck_q[swap_j];
            deck_q[swap_j] <= deck_q[idx_q];
        end
    end

    assign card       = card_q;
    assign card_valid = valid_q;
    assign cards_left = left_q;
    assign busy       = busy_q;
    assign deck_empty = empty_q;

endmodule

// File: tb/tb_card_dealer.sv
// Scoreboarded bench for card_dealer: a high-level Fisher-Yates deck model
// predicts each dealt card; a negedge monitor pops and compares on card_valid.
module tb_card_dealer;

    localparam int unsigned DECK  = 52;
    localparam logic [15:0] DSEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        shuffle_start = 1'b0;
    logic [15:0] seed = '0;
    logic        draw_req = 1'b0;
    logic [5:0]  card;
    logic        card_valid;
    logic [6:0]  cards_left;
    logic        busy;
    logic        deck_empty;

    card_dealer #(.DECK_SIZE(DECK), .DEFAULT_SEED(DSEED)) dut (
        .CLOCK_50      (clk),
        .resetn        (resetn),
        .shuffle_start (shuffle_start),
        .seed          (seed),
        .draw_req      (draw_req),
        .card          (card),
        .card_valid    (card_valid),
        .cards_left    (cards_left),
        .busy          (busy),
        .deck_empty    (deck_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        int card;
        int left;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    exp_t        exp_q[$];
    int          act_log[$];
    int          seq_a[$];
    int          m_order[DECK];
    int          pu_order[DECK];
    int          m_ptr;
    int          m_left;
    logic [15:0] m_lfsr;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Reference deck: identity fill, then Fisher-Yates driven by the LFSR.
    // Returns the number of LFSR draws (one per shuffle cycle).
    function automatic int model_shuffle(input logic [15:0] s, input bit reseed);
        int steps = 0;
        int i = DECK - 1;
        int j;
        int t;
        if (reseed) m_lfsr = (s == 16'h0) ? DSEED : s;
        for (int k = 0; k < DECK; k++) m_order[k] = k;
        while (i > 0) begin
            j = int'(m_lfsr[5:0]);
            m_lfsr = lfsr_step(m_lfsr);
            steps++;
            if (j <= i) begin
                t = m_order[i];
                m_order[i] = m_order[j];
                m_order[j] = t;
                i--;
            end
        end
        m_ptr  = 0;
        m_left = DECK;
        return steps;
    endfunction

    // Monitor: every card_valid strobe must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (resetn && card_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_card_valid", int'(card), -1);
            end else begin
                e = exp_q.pop_front();
                check("card", int'(card), e.card);
                check("cards_left_at_deal", int'(cards_left), e.left);
            end
            act_log.push_back(int'(card));
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (busy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("ready_timeout", int'(busy), 0);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drain", exp_q.size(), 0);
    endtask

    task automatic pulse_shuffle(input logic [15:0] s);
        @(negedge clk);
        shuffle_start = 1'b1;
        seed = s;
        void'(model_shuffle(s, 1'b1));
        @(negedge clk);
        shuffle_start = 1'b0;
        seed = 16'($urandom());
    endtask

    // One draw; dbl keeps draw_req high into the DEAL cycle, where it is dropped
    task automatic do_draw(input bit dbl);
        exp_t e;
        @(negedge clk);
        draw_req = 1'b1;
        if (m_left > 0) begin
            e.card = m_order[m_ptr];
            e.left = m_left - 1;
            exp_q.push_back(e);
            m_ptr++;
            m_left--;
        end
        @(negedge clk);
        draw_req = dbl;
        @(negedge clk);
        draw_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic deal_n(input int n);
        for (int k = 0; k < n; k++) do_draw(1'($urandom_range(0, 1)));
        drain();
    endtask

    function automatic int count_match(input int ref_arr[DECK]);
        int nm = 0;
        for (int k = 0; k < DECK; k++)
            if (k < act_log.size() && act_log[k] == ref_arr[k]) nm++;
        return nm;
    endfunction

    initial begin
        int n;
        int steps;
        int seen[DECK];
        int once;
        int ref_a[DECK];
        logic [15:0] s;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_card", int'(card), 0);
        check("rst_card_valid", int'(card_valid), 0);
        check("rst_cards_left", int'(cards_left), 0);
        check("rst_deck_empty", int'(deck_empty), 0);
        check("rst_busy", int'(busy), 1);

        // Power-up shuffle with DEFAULT_SEED, exact busy duration
        steps = model_shuffle(DSEED, 1'b1);
        pu_order = m_order;
        resetn = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 20000);
        check("busy_cycles_after_reset", n, DECK + steps);
        check("busy_at_least_2x_deck", int'(n >= 2 * DECK), 1);
        check("ready_cards_left", int'(cards_left), DECK);
        check("ready_deck_empty", int'(deck_empty), 0);

        // Ten cards, then card must hold its value
        deal_n(10);
        repeat (3) @(negedge clk);
        check("card_hold", int'(card), pu_order[9]);

        // Reset mid-deal; first card afterwards equals power-up first card
        resetn = 1'b0;
        @(negedge clk);
        check("midrst_card", int'(card), 0);
        check("midrst_card_valid", int'(card_valid), 0);
        check("midrst_cards_left", int'(cards_left), 0);
        check("midrst_busy", int'(busy), 1);
        check("midrst_deck_empty", int'(deck_empty), 0);
        void'(model_shuffle(DSEED, 1'b1));
        resetn = 1'b1;
        @(negedge clk);
        wait_ready();
        act_log.delete();
        deal_n(1);
        check("first_after_reset", (act_log.size() > 0) ? act_log[0] : -1, pu_order[0]);

        // Seed 1234: full deck, permutation, then empty
        pulse_shuffle(16'h1234);
        check("busy_after_shuffle_start", int'(busy), 1);
        check("cards_left_cleared", int'(cards_left), 0);
        wait_ready();
        check("full_deck_1234", int'(cards_left), DECK);
        act_log.delete();
        deal_n(DECK);
        for (int k = 0; k < DECK; k++) seen[k] = 0;
        foreach (act_log[k]) if (act_log[k] >= 0 && act_log[k] < DECK) seen[act_log[k]]++;
        once = 0;
        for (int k = 0; k < DECK; k++) if (seen[k] == 1) once++;
        check("each_value_once", once, DECK);
        check("empty_cards_left", int'(cards_left), 0);
        check("deck_empty_set", int'(deck_empty), 1);
        seq_a = act_log;

        // 53rd draw
`ifdef DEALER_AUTO_RESHUFFLE_EN
        begin
            exp_t e;
            void'(model_shuffle(16'h0, 1'b0));
            e.card = m_order[0];
            e.left = DECK - 1;
            exp_q.push_back(e);
            m_ptr  = 1;
            m_left = DECK - 1;
        end
        @(negedge clk);
        draw_req = 1'b1;
        @(negedge clk);
        draw_req = 1'b0;
        check("auto_busy_rises", int'(busy), 1);
        wait_ready();
        drain();
        check("auto_cards_left", int'(cards_left), DECK - 1);
`else
        @(negedge clk);
        draw_req = 1'b1;
        @(negedge clk);
        draw_req = 1'b0;
        repeat (4) @(negedge clk);
        check("no_auto_deck_empty", int'(deck_empty), 1);
        check("no_auto_busy", int'(busy), 0);
        check("no_auto_cards_left", int'(cards_left), 0);
`endif

        // Same seed again -> same order
        for (int k = 0; k < DECK; k++) ref_a[k] = (k < seq_a.size()) ? seq_a[k] : -1;
        pulse_shuffle(16'h1234);
        wait_ready();
        act_log.delete();
        deal_n(DECK);
        check("same_seed_same_order", count_match(ref_a), DECK);

        // Zero seed -> power-up order
        pulse_shuffle(16'h0000);
        wait_ready();
        act_log.delete();
        deal_n(DECK);
        check("seed0_matches_default", count_match(pu_order), DECK);

        // shuffle_start and draw_req together: shuffle wins
        pulse_shuffle(16'h2222);
        wait_ready();
        deal_n(1);
        @(negedge clk);
        draw_req = 1'b1;
        shuffle_start = 1'b1;
        seed = 16'h5555;
        void'(model_shuffle(16'h5555, 1'b1));
        @(negedge clk);
        draw_req = 1'b0;
        shuffle_start = 1'b0;
        check("collide_busy", int'(busy), 1);
        check("collide_cards_left", int'(cards_left), 0);
        check("collide_deck_empty", int'(deck_empty), 0);
        repeat (5) begin
            draw_req = 1'b1;
            @(negedge clk);
            draw_req = 1'b0;
            @(negedge clk);
        end
        wait_ready();
        deal_n(5);

        // Abort a shuffle in flight with a second seed
        pulse_shuffle(16'($urandom()));
        repeat ($urandom_range(3, 120)) @(negedge clk);
        pulse_shuffle(16'($urandom()));
        wait_ready();
        deal_n(int'($urandom_range(3, 20)));

        // Random seeds and random deal lengths
        repeat (3) begin
            s = 16'($urandom());
            pulse_shuffle(s);
            wait_ready();
            check("rand_full_deck", int'(cards_left), DECK);
            deal_n(int'($urandom_range(1, DECK)));
        end

        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
